// File: rtl/column_feed_pkg.sv
// -----------------------------------------------------------------------------
// column_feed_pkg
//   Shared helpers for the column_feed block.
//   - clog2_min1 : counter/address width for a count of n, never below 1 bit.
//   - col_flags_t: per-column sideband flags (valid / first / last).
// -----------------------------------------------------------------------------
package column_feed_pkg;

  // Width needed to count 0..n-1, clamped to at least one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic val;
    logic first;
    logic last;
  } col_flags_t;

endpackage : column_feed_pkg

// File: rtl/column_feed_line_buffer.sv
// -----------------------------------------------------------------------------
// column_feed_line_buffer
//   One image row of pixel storage, addressed by column. The read is
//   combinational so the stored (previous-row) pixel can be used in the same
//   beat that overwrites it: read-old / write-new.
// Ports
//   clk        in   clock, write on posedge
//   i_en       in   write enable (one accepted pixel beat)
//   i_addr     in   column address
//   i_wr_data  in   pixel written at i_addr
//   o_rd_data  out  pixel currently stored at i_addr (value before the write)
// -----------------------------------------------------------------------------
module column_feed_line_buffer #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rd_data = r_mem[i_addr];

  // NOTE: the storage array has no reset; stale contents are harmless because
  // the top level withholds dn_val until every buffered row has been rewritten.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end

endmodule : column_feed_line_buffer

// File: rtl/column_feed.sv
// -----------------------------------------------------------------------------
// column_feed
//   Turns a raster pixel stream into a HEIGHT_NB-tall column stream. Holds
//   HEIGHT_NB-1 chained line buffers; each accepted pixel yields one column
//   {oldest row, ..., previous row, current pixel}. Columns are only flagged
//   valid once HEIGHT_NB-1 full rows of the current frame are buffered.
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous reset, active-low
//   up_pix    in   raster pixel (row-major)
//   up_val    in   up_pix valid; no back-pressure
//   dn_img    out  column; top slice = oldest row, slice 0 = current pixel
//   dn_val    out  dn_img valid (one cycle after the accepted beat)
//   dn_first  out  with dn_val: column 0 of an output row
//   dn_last   out  with dn_val: last column of the frame
// -----------------------------------------------------------------------------
module column_feed
  import column_feed_pkg::*;
#(
  parameter int HEIGHT_NB = 3,
  parameter int IMG_WIDTH = 16,
  parameter int IMG_COLS  = 64,
  parameter int IMG_ROWS  = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [IMG_WIDTH-1:0]           up_pix,
  input  logic                           up_val,
  output logic [HEIGHT_NB*IMG_WIDTH-1:0] dn_img,
  output logic                           dn_val,
  output logic                           dn_first,
  output logic                           dn_last
);

  localparam int COL_W = clog2_min1(IMG_COLS);
  localparam int ROW_W = clog2_min1(IMG_ROWS);
  localparam int NB_LB = HEIGHT_NB - 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_PRIME = ROW_W'(HEIGHT_NB - 1);

  logic [COL_W-1:0] r_col_cnt;
  logic [ROW_W-1:0] r_row_cnt;

  logic [IMG_WIDTH-1:0] w_lb_rd [NB_LB];
  logic [IMG_WIDTH-1:0] w_lb_wr [NB_LB];

  logic                           w_col_last;
  logic                           w_row_last;
  logic                           w_primed;
  col_flags_t                     w_flags;
  logic [HEIGHT_NB*IMG_WIDTH-1:0] w_column;

  assign w_col_last = (r_col_cnt == COL_LAST);
  assign w_row_last = (r_row_cnt == ROW_LAST);
  assign w_primed   = (r_row_cnt >= ROW_PRIME);

  // Line buffer chain: buffer 0 takes the live pixel, buffer k takes what
  // buffer k-1 held at this column, so each row shifts one buffer deeper.
  for (genvar k = 0; k < NB_LB; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign w_lb_wr[k] = up_pix;
    end else begin : g_tail
      assign w_lb_wr[k] = w_lb_rd[k-1];
    end

    column_feed_line_buffer #(
      .DEPTH  (IMG_COLS),
      .WIDTH  (IMG_WIDTH),
      .ADDR_W (COL_W)
    ) u_lb (
      .clk       (clk),
      .i_en      (up_val),
      .i_addr    (r_col_cnt),
      .i_wr_data (w_lb_wr[k]),
      .o_rd_data (w_lb_rd[k])
    );
  end

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_column              = '0;
    w_column[0+:IMG_WIDTH] = up_pix;
    for (int k = 0; k < NB_LB; k++) begin
      w_column[(k+1)*IMG_WIDTH +: IMG_WIDTH] = w_lb_rd[k];
    end
  end

  always_comb begin
    w_flags       = '0;
    w_flags.val   = up_val && w_primed;
    w_flags.first = up_val && w_primed && (r_col_cnt == '0);
    w_flags.last  = up_val && w_primed && w_row_last && w_col_last;
  end

  // Raster position of the next accepted pixel. Row wrap at frame end
  // re-enters priming with no bubble.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (up_val) begin
      if (w_col_last) begin
        r_col_cnt <= '0;
        r_row_cnt <= w_row_last ? '0 : r_row_cnt + 1'b1;
      end else begin
        r_col_cnt <= r_col_cnt + 1'b1;
      end
    end
  end

  // Output stage: dn_img tracks the last accepted column; flags are
  // single-cycle pulses that drop on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_img   <= '0;
      dn_val   <= 1'b0;
      dn_first <= 1'b0;
      dn_last  <= 1'b0;
    end else begin
      dn_val   <= w_flags.val;
      dn_first <= w_flags.first;
      dn_last  <= w_flags.last;
      if (up_val) begin
        dn_img <= w_column;
      end
    end
  end

endmodule : column_feed

// File: tb/tb_column_feed.sv
// -----------------------------------------------------------------------------
// tb_column_feed
//   Directed + randomized bench for column_feed (HEIGHT_NB=3, 4x4 frames,
//   16-bit pixels). Expected columns come from a frame array: a pixel at
//   (r,c) with r>=2 yields {img[r-2][c], img[r-1][c], pix}.
// -----------------------------------------------------------------------------
module tb_column_feed;

  localparam int H    = 3;
  localparam int W    = 16;
  localparam int COLS = 4;
  localparam int ROWS = 4;

  logic           clk    = 1'b0;
  logic           rst_n  = 1'b1;
  logic [W-1:0]   up_pix = '0;
  logic           up_val = 1'b0;
  logic [H*W-1:0] dn_img;
  logic           dn_val;
  logic           dn_first;
  logic           dn_last;

  column_feed #(
    .HEIGHT_NB (H),
    .IMG_WIDTH (W),
    .IMG_COLS  (COLS),
    .IMG_ROWS  (ROWS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_pix   (up_pix),
    .up_val   (up_val),
    .dn_img   (dn_img),
    .dn_val   (dn_val),
    .dn_first (dn_first),
    .dn_last  (dn_last)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0]   img [ROWS][COLS];
  int             m_row;
  int             m_col;
  logic [H*W-1:0] last_img;
  bit             img_known;
  int             n_out;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] p(input int r, input int c, input int base);
    return W'(((r * COLS + c) << 4) + base);
  endfunction

  // One clock cycle: present (v, pix), predict, clock, then compare #1 later.
  task automatic step(input logic v, input logic [W-1:0] pix);
    logic           exp_v;
    logic           exp_f;
    logic           exp_l;
    logic [H*W-1:0] exp_img;
    exp_v   = 1'b0;
    exp_f   = 1'b0;
    exp_l   = 1'b0;
    exp_img = last_img;
    if (v) begin
      if (m_row >= H - 1) begin
        exp_v   = 1'b1;
        exp_img = {img[m_row-2][m_col], img[m_row-1][m_col], pix};
        exp_f   = (m_col == 0);
        exp_l   = (m_row == ROWS - 1) && (m_col == COLS - 1);
      end
      img[m_row][m_col] = pix;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
      end
    end
    up_val = v;
    up_pix = pix;
    @(posedge clk);
    #1;
    check("dn_val", 64'(dn_val), 64'(exp_v));
    check("dn_first", 64'(dn_first), 64'(exp_f));
    check("dn_last", 64'(dn_last), 64'(exp_l));
    if (exp_v) begin
      check("dn_img", 64'(dn_img), 64'(exp_img));
      last_img  = exp_img;
      img_known = 1'b1;
      n_out++;
    end else if (v) begin
      img_known = 1'b0;
    end else if (img_known) begin
      check("dn_img_hold", 64'(dn_img), 64'(last_img));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_val"}, 64'(dn_val), 64'd0);
    check({tag, "_first"}, 64'(dn_first), 64'd0);
    check({tag, "_last"}, 64'(dn_last), 64'd0);
    check({tag, "_img"}, 64'(dn_img), 64'd0);
  endtask

  // Reset is asserted and released #1 after a rising edge, away from it.
  task automatic do_reset(input int cycles, input bit check_img);
    rst_n = 1'b0;
    #1;
    check("rst_now_val", 64'(dn_val), 64'd0);
    if (check_img) check("rst_now_img", 64'(dn_img), 64'd0);
    for (int i = 0; i < cycles; i++) begin
      up_val = i[0];
      up_pix = W'($urandom);
      @(posedge clk);
      #1;
      check_outputs_zero("rst");
    end
    rst_n     = 1'b1;
    up_val    = 1'b0;
    m_row     = 0;
    m_col     = 0;
    img_known = 1'b0;
    last_img  = '0;
  endtask

  task automatic random_gap(input int one_in);
    if ($urandom_range(0, one_in - 1) == 0) begin
      repeat ($urandom_range(1, 3)) step(1'b0, W'($urandom));
    end
  endtask

  initial begin
    m_row     = 0;
    m_col     = 0;
    img_known = 1'b0;
    last_img  = '0;
    n_out     = 0;
    @(posedge clk);
    #1;

    // Reset held 6 cycles with up_val toggling
    do_reset(6, 1'b1);

    // Full frame, continuous valid, directed pixel values
    n_out = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        step(1'b1, p(r, c, 0));
        if (r == 2 && c == 0) check("f1_first_col", 64'(dn_img), 64'h0000_0040_0080);
        if (r == 2 && c == 0) check("f1_first_flag", 64'(dn_first), 64'd1);
        if (r == 3 && c == 0) check("f1_row4_first", 64'(dn_first), 64'd1);
        if (r == 3 && c == 3) check("f1_last_col", 64'(dn_img), 64'h0070_00B0_00F0);
        if (r == 3 && c == 3) check("f1_last_flag", 64'(dn_last), 64'd1);
      end
    end
    check("f1_out_count", 64'(n_out), 64'd8);
    step(1'b0, '0);

    // Same frame with random idle gaps
    n_out = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        random_gap(3);
        step(1'b1, p(r, c, 0));
      end
    end
    check("gap_out_count", 64'(n_out), 64'd8);
    check("gap_last_col", 64'(last_img), 64'h0070_00B0_00F0);

    // Two frames back-to-back, second offset by 0x100
    n_out = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          step(1'b1, p(r, c, f * 'h100));
          if (f == 1 && r == 2 && c == 0) check("f2_first_col", 64'(dn_img), 64'h0100_0140_0180);
        end
      end
      check("b2b_out_count", 64'(n_out), 64'(8 * (f + 1)));
    end

    // Reset after row 2, col 1, then a fresh frame
    for (int i = 0; i < 10; i++) step(1'b1, p(i / COLS, i % COLS, 'h200));
    check("pre_rst_val", 64'(dn_val), 64'd1);
    do_reset(1, 1'b0);
    n_out = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        step(1'b1, p(r, c, 0));
        if (r < 2) check("post_rst_prime", 64'(dn_val), 64'd0);
        if (r == 2 && c == 0) check("post_rst_first", 64'(dn_img), 64'h0000_0040_0080);
      end
    end
    check("post_rst_count", 64'(n_out), 64'd8);

    // Random pixels, random gaps, several back-to-back frames
    n_out = 0;
    for (int i = 0; i < 6 * ROWS * COLS; i++) begin
      random_gap(4);
      step(1'b1, W'($urandom));
    end
    check("rand_out_count", 64'(n_out), 64'd48);
    step(1'b0, '0);
    step(1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_column_feed
